// File: rtl/quad_pkg.sv
// Shared encodings and transition classification for the quadrature decoder.
// Phase pairs are {A,B}; DIR_UP marks forward motion.
package quad_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int unsigned DEBOUNCE_DEFAULT = 32'd4;

    typedef enum logic [1:0] {
        TR_NONE    = 2'b00,
        TR_FWD     = 2'b01,
        TR_REV     = 2'b10,
        TR_ILLEGAL = 2'b11
    } trans_e;

    // Gray-code step classification: one bit changing is a step, two is illegal.
    function automatic trans_e classify(input logic [1:0] prev_pair, input logic [1:0] cur_pair);
        trans_e t;
        t = TR_NONE;
        case ({prev_pair, cur_pair})
            {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: t = TR_FWD;
            {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: t = TR_REV;
            {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: t = TR_ILLEGAL;
            default: t = TR_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder inputs, error clear and step/direction/error outputs of the decoder.
interface quad_decoder_if;
    logic enc_a;
    logic enc_b;
    logic err_clear;
    logic step;
    logic step_dir;
    logic error;

    modport master (output enc_a, output enc_b, output err_clear,
                    input step, input step_dir, input error);
    modport slave  (input enc_a, input enc_b, input err_clear,
                    output step, output step_dir, output error);
endinterface

// File: rtl/quad_debounce.sv
// Two-flop synchronizer followed by a stable-count debounce filter for one channel.
// During reset the filtered value tracks the synchronized input so nothing is pending on release.
module quad_debounce
    import quad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync_out,
    output logic filt_out
);

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 32'd1);

    logic       sync1_r;
    logic       sync2_r;
    logic       filt_r;
    logic [7:0] cnt_r;

    // Synchronizer flops sample continuously, reset or not.
    always_ff @(posedge clk) begin
        sync1_r <= din;
        sync2_r <= sync1_r;
    end

    // Accept a new level only after it differed from the filtered value long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= 8'd0;
            filt_r <= sync2_r;
        end else if (sync2_r == filt_r) begin
            cnt_r  <= 8'd0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= 8'd0;
            filt_r <= sync2_r;
        end else begin
            cnt_r  <= cnt_r + 8'd1;
        end
    end

    assign sync_out = sync2_r;
    assign filt_out = filt_r;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: per-channel debounce, transition decode into a registered
// step pulse with direction, and a sticky illegal-transition flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    quad_decoder_if.slave bus
);

    logic       sync_a_s;
    logic       sync_b_s;
    logic       filt_a_s;
    logic       filt_b_s;
    logic [1:0] cur_pair_s;
    logic [1:0] prev_pair_r;
    trans_e     trans_s;

    logic       step_nxt_s;
    logic       dir_nxt_s;
    logic       err_nxt_s;
    logic       step_r;
    logic       step_dir_r;
    logic       error_r;

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk      (clk),
        .reset    (reset),
        .din      (bus.enc_a),
        .sync_out (sync_a_s),
        .filt_out (filt_a_s)
    );

    quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk      (clk),
        .reset    (reset),
        .din      (bus.enc_b),
        .sync_out (sync_b_s),
        .filt_out (filt_b_s)
    );

    assign cur_pair_s = {filt_a_s, filt_b_s};
    assign trans_s    = classify(prev_pair_r, cur_pair_s);

    // Next-state decode; an illegal jump sets error even if err_clear is high.
    always_comb begin
        step_nxt_s = 1'b0;
        dir_nxt_s  = step_dir_r;
        err_nxt_s  = error_r;
        case (trans_s)
            TR_FWD: begin
                step_nxt_s = 1'b1;
                dir_nxt_s  = DIR_UP;
            end
            TR_REV: begin
                step_nxt_s = 1'b1;
                dir_nxt_s  = DIR_DOWN;
            end
            default: begin
                step_nxt_s = 1'b0;
            end
        endcase
        if (trans_s == TR_ILLEGAL) begin
            err_nxt_s = 1'b1;
        end else if (bus.err_clear) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = error_r;
        end
    end

    // Output registers and reference pair; reset aligns the reference with the inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_r      <= 1'b0;
            step_dir_r  <= DIR_UP;
            error_r     <= 1'b0;
            prev_pair_r <= {sync_a_s, sync_b_s};
        end else begin
            step_r      <= step_nxt_s;
            step_dir_r  <= dir_nxt_s;
            error_r     <= err_nxt_s;
            prev_pair_r <= cur_pair_s;
        end
    end

    assign bus.step     = step_r;
    assign bus.step_dir = step_dir_r;
    assign bus.error    = error_r;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: stimulus pushes expected step arrival cycle and
// direction into a queue; a negedge monitor pops and compares on every step pulse.
module tb_quad_decoder;
    import quad_pkg::*;

    localparam int N    = 4;
    localparam int LAT  = N + 3;
    localparam int HOLD = 10;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       cnt_clr;
    logic [3:0] cnt4;
    int         cycle_cnt = 0;
    int         checks = 0;
    int         passed = 0;
    exp_t       exp_q[$];

    quad_decoder_if bus();

    quad_decoder #(.DEBOUNCE_CYCLES(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Counter driven by step/step_dir as a downstream consumer would use them.
    always @(posedge clk) begin
        if (cnt_clr) cnt4 <= 4'h0;
        else if (bus.step) cnt4 <= bus.step_dir ? cnt4 + 4'h1 : cnt4 - 4'h1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cycle_cnt);
    endtask

    // Monitor: every sampled step pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.step !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_step: got step=%b dir=%b expected no step (cycle %0d)",
                         bus.step, bus.step_dir, cycle_cnt);
            end else begin
                e = exp_q.pop_front();
                check("step_cycle", cycle_cnt, e.cyc);
                check("step_dir", {31'd0, bus.step_dir}, {31'd0, e.dir});
            end
        end
    end

    // kind: 0 none, 1 up, 2 down, 3 illegal (no step)
    task automatic drive_pair(input logic [1:0] pair, input int kind);
        @(negedge clk);
        bus.enc_a = pair[1];
        bus.enc_b = pair[0];
        if (kind == 1) exp_q.push_back(exp_t'{cyc: cycle_cnt + LAT, dir: 1'b1});
        else if (kind == 2) exp_q.push_back(exp_t'{cyc: cycle_cnt + LAT, dir: 1'b0});
        repeat (HOLD - 1) @(negedge clk);
    endtask

    logic [1:0] rev_seq [4];
    logic [3:0] rev_cnt [4];

    initial begin
        rev_seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        rev_cnt = '{4'hF, 4'hE, 4'hD, 4'hC};
        reset = 1'b1;
        cnt_clr = 1'b1;
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b1;
        bus.err_clear = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        cnt_clr = 1'b0;

        // Release with both channels high: nothing may fire.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i % 5 == 0) begin
                check("post_reset_error", {31'd0, bus.error}, 32'd0);
                check("post_reset_dir", {31'd0, bus.step_dir}, 32'd1);
            end
        end

        // Reach 00 forward, then one full forward cycle including 10->00 wrap.
        drive_pair(2'b10, 1);
        drive_pair(2'b00, 1);
        drive_pair(2'b01, 1);
        drive_pair(2'b11, 1);
        drive_pair(2'b10, 1);
        drive_pair(2'b00, 1);

        // Reverse cycle including 00->10 wrap, counter 0->F->E->D->C.
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_pair(rev_seq[i], 2);
            check("rev_counter", {28'd0, cnt4}, {28'd0, rev_cnt[i]});
        end
        check("rev_dir", {31'd0, bus.step_dir}, 32'd0);

        // Glitch on A shorter than the debounce window.
        @(negedge clk); bus.enc_a = 1'b1;
        repeat (3) @(negedge clk);
        bus.enc_a = 1'b0;
        repeat (HOLD) @(negedge clk);
        check("glitch_error", {31'd0, bus.error}, 32'd0);

        // A high for exactly the debounce window is accepted: down then up.
        @(negedge clk); bus.enc_a = 1'b1;
        exp_q.push_back(exp_t'{cyc: cycle_cnt + LAT, dir: 1'b0});
        repeat (N) @(negedge clk);
        bus.enc_a = 1'b0;
        exp_q.push_back(exp_t'{cyc: cycle_cnt + LAT, dir: 1'b1});
        repeat (HOLD + 2) @(negedge clk);

        // Illegal 00->11: error set and sticky, direction untouched.
        drive_pair(2'b11, 3);
        check("illegal_error", {31'd0, bus.error}, 32'd1);
        check("illegal_dir", {31'd0, bus.step_dir}, 32'd1);
        repeat (HOLD) @(negedge clk);
        check("error_sticky", {31'd0, bus.error}, 32'd1);
        @(negedge clk); bus.err_clear = 1'b1;
        @(negedge clk); bus.err_clear = 1'b0;
        check("error_cleared", {31'd0, bus.error}, 32'd0);

        // 11->01 legal, then 01->10 jump with err_clear on the same edge.
        drive_pair(2'b01, 2);
        @(negedge clk);
        bus.enc_a = 1'b1;
        bus.enc_b = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        bus.err_clear = 1'b1;
        @(negedge clk);
        bus.err_clear = 1'b0;
        check("set_wins_error", {31'd0, bus.error}, 32'd1);
        check("set_wins_dir", {31'd0, bus.step_dir}, 32'd0);
        repeat (5) @(negedge clk);

        // Reset two cycles into a pending 10->00 change: change is dropped.
        @(negedge clk); bus.enc_a = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (HOLD + 2) @(negedge clk);
        check("mid_reset_error", {31'd0, bus.error}, 32'd0);
        check("mid_reset_dir", {31'd0, bus.step_dir}, 32'd1);
        drive_pair(2'b10, 2);
        drive_pair(2'b11, 2);
        drive_pair(2'b01, 2);

        repeat (HOLD) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the consecutive stable cycles required to accept an input change (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port enc_a  input  1  quadrature channel A, asynchronous to clk, may bounce.
REQ-005 The block SHALL have port enc_b  input  1  quadrature channel B, asynchronous to clk, may bounce.
REQ-006 The block SHALL have port err_clear  input  1  clears the sticky error flag.
REQ-007 The block SHALL have port step  output  1  one-cycle pulse per accepted quadrature transition; directly drives a counter enable.
REQ-008 The block SHALL have port step_dir  output  1  direction of the last accepted step: 1 = up/forward, 0 = down/reverse; directly drives a counter direction input.
REQ-009 The block SHALL have port error  output  1  sticky flag: an illegal transition was detected.

Function
REQ-010 Each channel SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Each channel SHALL have an independent debounce: a counter increments while the synchronized value differs from the filtered value, resets to 0 when they are equal, and on reaching DEBOUNCE_CYCLES loads the synchronized value into the filtered value and resets to 0.
REQ-012 The decoder SHALL compare the filtered pair {A,B} with its value from the previous cycle; forward sequence 00->01->11->10->00, reverse sequence 00->10->11->01->00.
REQ-013 A forward transition SHALL assert step for exactly one cycle with step_dir=1; a reverse transition SHALL assert step for one cycle with step_dir=0.
REQ-014 An unchanged pair SHALL leave step=0 and step_dir unchanged.
REQ-015 A change of both bits in the same cycle (00<->11, 01<->10) SHALL be illegal: step stays 0, step_dir unchanged, error set to 1, and the decoder adopts the new pair as its reference.
REQ-016 step and step_dir SHALL be registered outputs; a raw input change first captured at clk edge k SHALL produce step high during the cycle following edge k+DEBOUNCE_CYCLES+2 (fixed latency DEBOUNCE_CYCLES+3 edges).
REQ-017 Input glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no step and no error.
REQ-018 error SHALL remain 1 until err_clear is sampled high; if err_clear and a new illegal transition occur in the same cycle, error SHALL be 1 afterwards (set wins).
REQ-019 Wrap-around 10->00 (forward) and 00->10 (reverse) SHALL be treated like any other legal transition.

Reset
REQ-020 While reset is high: step=0, step_dir=1, error=0, debounce counters=0; synchronizer flops keep sampling, and filtered and previous pairs load the synchronized inputs directly so no step or error fires on reset release.
REQ-021 Reset asserted mid-debounce SHALL discard the pending change; no step SHALL issue for it.

Structure
REQ-022 A shared package quad_pkg SHALL hold the phase encodings (PH_00, PH_01, PH_11, PH_10), DIR_UP=1, DIR_DOWN=0 and the default DEBOUNCE_CYCLES.
REQ-023 The synchronizer plus debounce SHALL be one sub-module, quad_debounce, instantiated once per channel; transition decode and error logic SHALL live in quad_decoder.

Verification
REQ-024 Reset with A=B=1 held, release -> step=0, error=0, step_dir=1 for 20 cycles.
REQ-025 Clean forward cycle 00->01->11->10->00, each phase held 10 cycles, DEBOUNCE_CYCLES=4 -> exactly 4 step pulses, step_dir=1, each at latency 7 edges from the phase change.
REQ-026 Reverse cycle 00->10->11->01->00 -> 4 step pulses with step_dir=0; a driven 4-bit counter goes 0->F->E->D->C.
REQ-027 A toggles for 3 cycles then returns (glitch < DEBOUNCE_CYCLES) -> no step, no error.
REQ-028 Pair jumps 00->11 in one cycle -> no step, error=1 and held; err_clear pulse -> error=0; err_clear coincident with 01->10 jump -> error=1.
REQ-029 Reset asserted 2 cycles into a pending A change and released with the input still changed -> no step pulse; subsequent legal transitions decode normally.
